rms_window_estimator: RTL and testbench

// Windowed RMS estimator for the VPPM receiver front end, between the ADC/filter chain and threshold logic.

---
 rtl/rms_window_estimator.sv | 151 +++++++++++++++
 tb/tb_rms_window_estimator.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rms_window_estimator.sv
// rms_window_estimator: windowed mean square of signed samples and its integer square root
// via Newton-Raphson iteration, using a sequential restoring divider.
module rms_window_estimator #(
    parameter int DATA_W   = 16,
    parameter int WIN_LOG2 = 12,
    parameter int SKIP     = 96,
    parameter int NR_ITER  = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_valid,
    input  logic signed [DATA_W-1:0]  data_in,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_W-1:0]         rms_out,
    output logic [2*DATA_W-1:0]       mean_sq,
    output logic                      not_conv
);
    localparam int SW   = 2 * DATA_W;
    localparam int AW   = SW + WIN_LOG2;
    localparam int MAXC = (SKIP > (1 << WIN_LOG2)) ? SKIP : (1 << WIN_LOG2);
    localparam int CW   = $clog2(MAXC + SW + 1);
    localparam int IW   = $clog2(NR_ITER + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SKIP = 3'd1;
    localparam logic [2:0] S_ACC  = 3'd2;
    localparam logic [2:0] S_MEAN = 3'd3;
    localparam logic [2:0] S_DIV  = 3'd4;
    localparam logic [2:0] S_UPD  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam logic [CW-1:0]     SKIP_LAST = CW'(SKIP - 1);
    localparam logic [CW-1:0]     WIN_LAST  = CW'((1 << WIN_LOG2) - 1);
    localparam logic [CW-1:0]     DIV_LAST  = CW'(SW - 1);
    localparam logic [IW-1:0]     ITER_LAST = IW'(NR_ITER - 1);
    localparam logic [DATA_W-1:0] X0        = DATA_W'(1 << (DATA_W - 1));

    logic [2:0]        state;
    logic [AW-1:0]     acc;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     iter;
    logic [SW-1:0]     m;
    logic [SW-1:0]     quo;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] res_x;
    logic              nc;

    logic [SW-1:0]     sq;
    logic [SW-1:0]     mean_w;
    logic [DATA_W:0]   x_ext;
    logic [DATA_W:0]   div_t;
    logic              div_ge;
    logic [DATA_W-1:0] rem_nx;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] xn;

    assign sq     = SW'(data_in) * SW'(data_in);
    assign mean_w = acc[AW-1:WIN_LOG2];
    assign x_ext  = {1'b0, x};
    // one restoring step: shift the next dividend bit into the partial remainder
    assign div_t  = {rem, quo[SW-1]};
    assign div_ge = div_t >= x_ext;
    assign rem_nx = div_ge ? DATA_W'(div_t - x_ext) : div_t[DATA_W-1:0];
    assign sum    = x_ext + quo[DATA_W:0];
    assign xn     = DATA_W'(sum >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            acc      <= '0;
            cnt      <= '0;
            iter     <= '0;
            m        <= '0;
            quo      <= '0;
            x        <= '0;
            rem      <= '0;
            res_x    <= '0;
            nc       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rms_out  <= '0;
            mean_sq  <= '0;
            not_conv <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    busy  <= 1'b1;
                    acc   <= '0;
                    cnt   <= '0;
                    iter  <= '0;
                    nc    <= 1'b0;
                    state <= (SKIP == 0) ? S_ACC : S_SKIP;
                end
                S_SKIP: if (in_valid) begin
                    cnt   <= (cnt == SKIP_LAST) ? '0 : cnt + 1'b1;
                    state <= (cnt == SKIP_LAST) ? S_ACC : S_SKIP;
                end
                S_ACC: if (in_valid) begin
                    acc   <= acc + AW'(sq);
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == WIN_LAST) ? S_MEAN : S_ACC;
                end
                S_MEAN: begin
                    m     <= mean_w;
                    quo   <= mean_w;
                    rem   <= '0;
                    cnt   <= '0;
                    x     <= X0;
                    res_x <= '0;
                    state <= (mean_w == '0) ? S_DONE : S_DIV;
                end
                S_DIV: begin
                    rem   <= rem_nx;
                    quo   <= {quo[SW-2:0], div_ge};
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == DIV_LAST) ? S_UPD : S_DIV;
                end
                S_UPD: begin
                    iter <= iter + 1'b1;
                    if (xn >= x) begin
                        res_x <= x;
                        state <= S_DONE;
                    end else if (iter == ITER_LAST) begin
                        res_x <= xn;
                        nc    <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        x     <= xn;
                        quo   <= m;
                        rem   <= '0;
                        cnt   <= '0;
                        state <= S_DIV;
                    end
                end
                S_DONE: begin
                    rms_out  <= res_x;
                    mean_sq  <= m;
                    not_conv <= nc;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rms_window_estimator.sv
// tb_rms_window_estimator: directed measurements on two configurations, checked every cycle
// against a plain-arithmetic model of mean square, Newton sequence and result timing.
module tb_rms_window_estimator;
    localparam int NEVER = 32'h7fffffff;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        start = 2'b00;
    logic              in_valid = 1'b0;
    logic signed [15:0] data_in = '0;
    logic              busy_o [2];
    logic              done_o [2];
    logic              nc_o [2];
    logic [15:0]       rms_o [2];
    logic [31:0]       msq_o [2];

    int     tests = 0;
    int     fails = 0;
    int     cyc = 0;
    int     s_cyc [2];
    int     d_cyc [2];
    longint cur_rms [2], cur_msq [2], pend_rms [2], pend_msq [2];
    bit     cur_nc [2], pend_nc [2];
    int     smp [32];
    bit     gap [32];
    bit     xst [32];
    int     nsmp;
    bit     xs_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rms_window_estimator #(.DATA_W(16), .WIN_LOG2(4), .SKIP(3), .NR_ITER(20)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid), .data_in(data_in),
        .busy(busy_o[0]), .done(done_o[0]), .rms_out(rms_o[0]), .mean_sq(msq_o[0]),
        .not_conv(nc_o[0]));

    rms_window_estimator #(.DATA_W(16), .WIN_LOG2(4), .SKIP(0), .NR_ITER(2)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid), .data_in(data_in),
        .busy(busy_o[1]), .done(done_o[1]), .rms_out(rms_o[1]), .mean_sq(msq_o[1]),
        .not_conv(nc_o[1]));

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // floor integer sqrt by Newton from 2**15 with early stop, iteration cap nr
    function automatic void newton(input longint m, input int nr, output longint rms,
                                   output bit nc, output int k);
        longint x, q, xn;
        rms = 0; nc = 1'b0; k = 0;
        if (m == 0) return;
        x = 32768;
        for (int it = 1; it <= nr; it++) begin
            q  = m / x;
            xn = ((x + q) % 131072) / 2;
            k  = it;
            if (xn >= x) begin rms = x; return; end
            if (it == nr) begin rms = xn; nc = 1'b1; return; end
            x = xn;
        end
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            s_cyc[d] = NEVER; d_cyc[d] = NEVER;
            cur_rms[d] = 0; cur_msq[d] = 0; cur_nc[d] = 1'b0;
            pend_rms[d] = 0; pend_msq[d] = 0; pend_nc[d] = 1'b0;
        end
    endtask

    always @(negedge clk) if (!rst) begin
        for (int d = 0; d < 2; d++) begin
            if (cyc == d_cyc[d]) begin
                cur_rms[d] = pend_rms[d]; cur_msq[d] = pend_msq[d]; cur_nc[d] = pend_nc[d];
            end
            chk($sformatf("busy%0d", d), busy_o[d], longint'(cyc > s_cyc[d] && cyc < d_cyc[d]));
            chk($sformatf("done%0d", d), done_o[d], longint'(cyc == d_cyc[d]));
            chk($sformatf("rms%0d", d), rms_o[d], cur_rms[d]);
            chk($sformatf("msq%0d", d), msq_o[d], cur_msq[d]);
            chk($sformatf("nc%0d", d), nc_o[d], longint'(cur_nc[d]));
        end
    end

    task automatic send(input int v, input bit st, input int d);
        in_valid = 1'b1; data_in = 16'(v); start[d] = st;
        @(posedge clk); #1;
        in_valid = 1'b0; start[d] = 1'b0;
    endtask

    task automatic measure(input int d);
        int skip, nr, k, lst;
        longint sum, rms;
        bit nc;
        skip = (d == 0) ? 3 : 0;
        nr = (d == 0) ? 20 : 2;
        sum = 0;
        s_cyc[d] = cyc; d_cyc[d] = NEVER;
        send(12345, 1'b1, d);   // sample alongside start must not count
        for (int i = 0; i < nsmp; i++) begin
            if (gap[i]) begin @(posedge clk); #1; end
            send(smp[i], xst[i], d);
        end
        lst = cyc;
        for (int i = skip; i < skip + 16; i++) sum += longint'(smp[i]) * smp[i];
        newton(sum >> 4, nr, rms, nc, k);
        pend_rms[d] = rms; pend_msq[d] = sum >> 4; pend_nc[d] = nc;
        d_cyc[d] = lst + 2 + k * 33;
        while (cyc <= d_cyc[d]) begin
            if (xs_en && (cyc == lst + 10 || cyc == d_cyc[d] - 1)) start[d] = 1'b1;
            @(posedge clk); #1;
            start[d] = 1'b0;
        end
    endtask

    task automatic fill(input int skip_v, input int skip_n);
        nsmp = skip_n + 16;
        for (int i = 0; i < 32; i++) begin
            smp[i] = (i < skip_n) ? skip_v : 0; gap[i] = 1'b0; xst[i] = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_busy", busy_o[d], 0);
            chk("reset_done", done_o[d], 0);
            chk("reset_rms", rms_o[d], 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        fill(30000, 3);
        for (int i = 0; i < 16; i++) smp[3 + i] = (i % 2) ? -100 : 100;
        measure(0);
        chk("t2_msq", msq_o[0], 10000);
        chk("t2_rms", rms_o[0], 100);
        chk("t2_nc", nc_o[0], 0);

        s_cyc[0] = cyc; d_cyc[0] = NEVER;
        send(0, 1'b1, 0);
        for (int i = 0; i < 8; i++) send(500, 1'b0, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy_o[0], 0);
        chk("arst_rms", rms_o[0], 0);
        chk("arst_msq", msq_o[0], 0);
        chk("arst_nc", nc_o[0], 0);
        chk("arst_done", done_o[0], 0);
        clear_model();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        fill(0, 3);
        for (int i = 0; i < 16; i++) smp[3 + i] = -32768;
        measure(0);
        chk("t3_msq", msq_o[0], 1073741824);
        chk("t3_rms", rms_o[0], 32768);
        chk("t3_nc", nc_o[0], 0);

        fill(-20000, 3);
        measure(0);
        chk("t4_msq", msq_o[0], 0);
        chk("t4_rms", rms_o[0], 0);

        fill(7, 3);
        for (int i = 0; i < 19; i++) begin
            gap[i] = (i % 3 == 1);
            xst[i] = (i % 4 == 2);
        end
        for (int i = 0; i < 16; i++) smp[3 + i] = i;
        xs_en = 1'b1;
        measure(0);
        xs_en = 1'b0;
        chk("t5_msq", msq_o[0], 77);
        chk("t5_rms", rms_o[0], 8);
        chk("t5_nc", nc_o[0], 0);
        repeat (3) @(posedge clk);
        #1;

        fill(0, 0);
        for (int i = 0; i < 16; i++) smp[i] = 3;
        measure(1);
        chk("t6_msq", msq_o[1], 9);
        chk("t6_rms", rms_o[1], 8192);
        chk("t6_nc", nc_o[1], 1);
        chk("t6_other_rms", rms_o[0], 8);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
